bot_app_if: RTL and testbench

BOT_APP_IF -- requirements
Module: bot_app_if

---
 rtl/bot_app_if.sv | 120 ++++++++++++
 tb/tb_bot_app_if.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bot_app_if.sv
// Bridge between the bot's live register set and an 8-bit port-mapped application CPU.
// Snapshots bot registers on update, raises an interrupt, tracks overruns and holds the motor command.
module bot_app_if #(
    parameter logic [7:0] PORT_BASE = 8'h0A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] LocX_in,
    input  logic [7:0] LocY_in,
    input  logic [7:0] Sensors_in,
    input  logic [7:0] BotInfo_in,
    input  logic [7:0] LMDist_in,
    input  logic [7:0] RMDist_in,
    input  logic       upd_sysregs,
    output logic [7:0] MotCtl_out,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    localparam int unsigned W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } irq_state_e;

    irq_state_e     irq_state_q;
    logic           upd_d_q;
    logic           overrun_q;
    logic [W-1:0]   cnt_q;
    logic [W-1:0]   motctl_q;
    logic [W-1:0]   in_port_q;
    logic [W-1:0]   locx_q, locy_q, sensors_q, botinfo_q, lmdist_q, rmdist_q;

    logic           upd_evt_c;
    logic           wr_mot_c;
    logic           wr_clr_c;
    logic           ovr_set_c;
    logic [W-1:0]   offset_c;
    logic [W-1:0]   rd_data_c;

    // Edge detect, write decode and registered read mux source
    always_comb begin
        upd_evt_c = upd_sysregs & ~upd_d_q;
        offset_c  = W'(port_id - PORT_BASE);
        wr_mot_c  = write_strobe && (offset_c == 8'h08);
        wr_clr_c  = write_strobe && (offset_c == 8'h09);
        ovr_set_c = upd_evt_c && (irq_state_q == PEND) && !interrupt_ack;
        rd_data_c = '0;
        case (offset_c)
            8'h00:   rd_data_c = locx_q;
            8'h01:   rd_data_c = locy_q;
            8'h02:   rd_data_c = botinfo_q;
            8'h03:   rd_data_c = sensors_q;
            8'h04:   rd_data_c = lmdist_q;
            8'h05:   rd_data_c = rmdist_q;
            8'h06:   rd_data_c = {6'b0, overrun_q, irq_state_q == PEND};
            8'h07:   rd_data_c = cnt_q;
            8'h08:   rd_data_c = motctl_q;
            default: rd_data_c = '0;
        endcase
    end

    // Interrupt state machine plus all datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_state_q <= IDLE;
            upd_d_q     <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
            motctl_q    <= '0;
            in_port_q   <= '0;
            locx_q      <= '0;
            locy_q      <= '0;
            sensors_q   <= '0;
            botinfo_q   <= '0;
            lmdist_q    <= '0;
            rmdist_q    <= '0;
        end else begin
            upd_d_q   <= upd_sysregs;
            in_port_q <= rd_data_c;

            case (irq_state_q)
                IDLE:    if (upd_evt_c) irq_state_q <= PEND;
                PEND:    if (interrupt_ack && !upd_evt_c) irq_state_q <= IDLE;
                default: irq_state_q <= IDLE;
            endcase

            // Set beats a same-cycle software clear
            if (ovr_set_c)     overrun_q <= 1'b1;
            else if (wr_clr_c) overrun_q <= 1'b0;

            if (upd_evt_c) begin
                cnt_q     <= W'(cnt_q + 8'd1);
                locx_q    <= LocX_in;
                locy_q    <= LocY_in;
                sensors_q <= Sensors_in;
                botinfo_q <= BotInfo_in;
                lmdist_q  <= LMDist_in;
                rmdist_q  <= RMDist_in;
            end

            if (wr_mot_c) motctl_q <= out_port;
        end
    end

    assign MotCtl_out = motctl_q;
    assign in_port    = in_port_q;
    assign interrupt  = (irq_state_q == PEND);

    // Reads are side-effect free; the strobe is accepted but unused
    logic unused_c;
    assign unused_c = read_strobe;

endmodule

// File: tb/tb_bot_app_if.sv
// Randomized and directed checks of bot_app_if against a register-map level reference model.
module tb_bot_app_if;

    localparam logic [7:0] BASE = 8'h0A;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] LocX_in, LocY_in, Sensors_in, BotInfo_in, LMDist_in, RMDist_in;
    logic       upd_sysregs;
    logic [7:0] MotCtl_out;
    logic [7:0] port_id, out_port;
    logic       write_strobe, read_strobe;
    logic [7:0] in_port;
    logic       interrupt, interrupt_ack;

    bot_app_if #(.PORT_BASE(BASE)) dut (
        .clk(clk), .reset(reset),
        .LocX_in(LocX_in), .LocY_in(LocY_in), .Sensors_in(Sensors_in),
        .BotInfo_in(BotInfo_in), .LMDist_in(LMDist_in), .RMDist_in(RMDist_in),
        .upd_sysregs(upd_sysregs), .MotCtl_out(MotCtl_out),
        .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: register map by offset (0..5 snapshots, 7 count, 8 motor)
    logic [7:0] m_map [0:8];
    logic       m_prev_upd, m_irq, m_ovr;
    logic [7:0] m_rd;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] addr);
        int off;
        off = int'(8'(addr - BASE));
        if (off == 6) return {6'b0, m_ovr, m_irq};
        if (off <= 8) return m_map[off];
        return 8'h00;
    endfunction

    task automatic model_step();
        logic       evt;
        int         off;
        if (reset) begin
            foreach (m_map[i]) m_map[i] = 8'h00;
            m_prev_upd = 1'b0; m_irq = 1'b0; m_ovr = 1'b0; m_rd = 8'h00;
            return;
        end
        evt  = upd_sysregs && !m_prev_upd;
        off  = int'(8'(port_id - BASE));
        m_rd = m_read(port_id);
        if (evt && m_irq && !interrupt_ack) m_ovr = 1'b1;
        else if (write_strobe && off == 9)  m_ovr = 1'b0;
        if (evt) begin
            m_map[0] = LocX_in;   m_map[1] = LocY_in;   m_map[2] = BotInfo_in;
            m_map[3] = Sensors_in; m_map[4] = LMDist_in; m_map[5] = RMDist_in;
            m_map[7] = 8'((m_map[7] + 1) % 256);
            m_irq = 1'b1;
        end else if (interrupt_ack) begin
            m_irq = 1'b0;
        end
        if (write_strobe && off == 8) m_map[8] = out_port;
        m_prev_upd = upd_sysregs;
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check8("interrupt", {7'b0, interrupt}, {7'b0, m_irq});
        check8("MotCtl_out", MotCtl_out, m_map[8]);
        check8("in_port", in_port, m_rd);
    endtask

    task automatic rd(input logic [7:0] off);
        port_id = 8'(BASE + off);
        cycle();
    endtask

    task automatic pulse();
        upd_sysregs = 1'b1; cycle();
        upd_sysregs = 1'b0; cycle();
    endtask

    initial begin
        reset = 1'b1; upd_sysregs = 1'b0; interrupt_ack = 1'b0;
        write_strobe = 1'b0; read_strobe = 1'b0; port_id = BASE; out_port = 8'h00;
        LocX_in = 8'h3C; LocY_in = 8'h51; Sensors_in = 8'h00;
        BotInfo_in = 8'h00; LMDist_in = 8'h00; RMDist_in = 8'h00;
        @(negedge clk);
        cycle(); cycle();
        reset = 1'b0;

        // Idle after reset
        rd(8'h00); check8("rst_locx", in_port, 8'h00);
        check8("rst_irq", {7'b0, interrupt}, 8'h00);
        rd(8'h07); check8("rst_cnt", in_port, 8'h00);

        // First update
        LocX_in = 8'h3C; Sensors_in = 8'hA5; upd_sysregs = 1'b1; cycle();
        upd_sysregs = 1'b0; LocX_in = 8'h11; Sensors_in = 8'h22; cycle();
        check8("upd1_irq", {7'b0, interrupt}, 8'h01);
        rd(8'h00); check8("upd1_locx", in_port, 8'h3C);
        rd(8'h03); check8("upd1_sens", in_port, 8'hA5);
        rd(8'h07); check8("upd1_cnt", in_port, 8'h01);

        // Overrun and software clear
        LocX_in = 8'h40; pulse();
        rd(8'h06); check8("ovr_status", in_port, 8'h03);
        rd(8'h00); check8("ovr_locx", in_port, 8'h40);
        port_id = 8'(BASE + 8'h09); out_port = 8'h5A; write_strobe = 1'b1; cycle();
        write_strobe = 1'b0;
        rd(8'h06); check8("clr_status", in_port, 8'h01);

        // Ack coinciding with update: update wins, no overrun
        upd_sysregs = 1'b1; interrupt_ack = 1'b1; cycle();
        upd_sysregs = 1'b0; interrupt_ack = 1'b0; cycle();
        check8("ackupd_irq", {7'b0, interrupt}, 8'h01);
        rd(8'h06); check8("ackupd_status", in_port, 8'h01);
        interrupt_ack = 1'b1; cycle(); interrupt_ack = 1'b0;
        check8("ack_irq", {7'b0, interrupt}, 8'h00);

        // Motor write, readback, unmapped read
        port_id = 8'(BASE + 8'h08); out_port = 8'h99; write_strobe = 1'b1; cycle();
        write_strobe = 1'b0;
        check8("mot_out", MotCtl_out, 8'h99);
        rd(8'h08); check8("mot_rd", in_port, 8'h99);
        port_id = 8'h30; cycle(); check8("unmapped", in_port, 8'h00);

        // Counter wrap, then reset while pending
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < 256; i++) pulse();
        rd(8'h07); check8("wrap_cnt", in_port, 8'h00);
        check8("wrap_irq", {7'b0, interrupt}, 8'h01);
        port_id = 8'(BASE + 8'h08); out_port = 8'h77; write_strobe = 1'b1; cycle();
        write_strobe = 1'b0; rd(8'h08);
        reset = 1'b1; upd_sysregs = 1'b1; interrupt_ack = 1'b1; cycle();
        check8("rst_irq2", {7'b0, interrupt}, 8'h00);
        check8("rst_mot2", MotCtl_out, 8'h00);
        check8("rst_inport2", in_port, 8'h00);

        // Update held high through reset release counts once
        interrupt_ack = 1'b0; reset = 1'b0; LocY_in = 8'hC3; cycle();
        check8("held_irq", {7'b0, interrupt}, 8'h01);
        upd_sysregs = 1'b0; rd(8'h01); check8("held_locy", in_port, 8'hC3);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            upd_sysregs   = ($urandom_range(0, 3) == 0);
            interrupt_ack = ($urandom_range(0, 4) == 0);
            write_strobe  = ($urandom_range(0, 3) == 0);
            read_strobe   = ($urandom_range(0, 1) == 0);
            port_id       = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                        : 8'(BASE + 8'($urandom_range(0, 10)));
            out_port   = 8'($urandom); LocX_in   = 8'($urandom); LocY_in   = 8'($urandom);
            Sensors_in = 8'($urandom); BotInfo_in = 8'($urandom); LMDist_in = 8'($urandom);
            RMDist_in  = 8'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
